// File: rtl/ksa.sv
`default_nettype none
// ============================================================================
//  Module   : ksa
//  Purpose  : ARC4 key-scheduling engine. Walks i = 0..255 over a single-port
//             synchronous S memory, accumulating j and swapping S[i] / S[j].
//             Each step takes six cycles: read i, capture S[i], read j,
//             capture S[j], write S[i], write S[j].
//  Revision : 1.0 - initial release
// ============================================================================
module ksa #(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             addr,
  input  logic [7:0]             rddata,
  output logic [7:0]             wrdata,
  output logic                   wren
);

  // Key-byte index width; a 1-byte key still gets a 1-bit index that stays 0.
  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KIDX_W-1:0] C_KIDX_LAST = KIDX_W'(KEY_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_I  = 3'd1,
    ST_CAP_I = 3'd2,
    ST_RD_J  = 3'd3,
    ST_CAP_J = 3'd4,
    ST_WR_I  = 3'd5,
    ST_WR_J  = 3'd6
  } state_t;

  state_t                   state_q, state_d;
  logic [7:0]               i_q, i_d;
  logic [7:0]               j_q, j_d;
  logic [KIDX_W-1:0]        kidx_q, kidx_d;
  logic [7:0]               si_q, si_d;
  logic [7:0]               sj_q, sj_d;
  logic [8*KEY_BYTES-1:0]   key_q, key_d;
  logic [7:0]               key_byte;

  // Select the current key byte; byte 0 sits in the most significant lane.
  always_comb begin
    key_byte = 8'h00;
    for (int k = 0; k < KEY_BYTES; k++) begin
      if (kidx_q == KIDX_W'(k)) begin
        key_byte = key_q[8*(KEY_BYTES-1-k) +: 8];
      end
    end
  end

  // State and datapath registers; reset returns the engine to a clean idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      i_q     <= 8'h00;
      j_q     <= 8'h00;
      kidx_q  <= '0;
      si_q    <= 8'h00;
      sj_q    <= 8'h00;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      kidx_q  <= kidx_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      key_q   <= key_d;
    end
  end

  // Next-state and datapath updates for the six-cycle swap step.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    kidx_d  = kidx_q;
    si_d    = si_q;
    sj_d    = sj_q;
    key_d   = key_q;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          i_d     = 8'h00;
          j_d     = 8'h00;
          kidx_d  = '0;
          key_d   = key;
          state_d = ST_RD_I;
        end
      end
      ST_RD_I:  state_d = ST_CAP_I;
      ST_CAP_I: begin
        // rddata holds S[i] now: the RAM registered addr=i on the previous edge.
        si_d    = rddata;
        j_d     = j_q + rddata + key_byte;
        state_d = ST_RD_J;
      end
      ST_RD_J:  state_d = ST_CAP_J;
      ST_CAP_J: begin
        sj_d    = rddata;
        state_d = ST_WR_I;
      end
      ST_WR_I:  state_d = ST_WR_J;
      ST_WR_J: begin
        if (i_q == 8'hFF) begin
          i_d     = 8'h00;
          state_d = ST_IDLE;
        end else begin
          i_d     = i_q + 8'h01;
          kidx_d  = (kidx_q == C_KIDX_LAST) ? '0 : kidx_q + KIDX_W'(1);
          state_d = ST_RD_I;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Memory-port outputs decoded purely from state and registers.
  always_comb begin
    rdy    = 1'b0;
    wren   = 1'b0;
    addr   = i_q;
    wrdata = 8'h00;
    case (state_q)
      ST_IDLE:  rdy = 1'b1;
      ST_RD_J,
      ST_CAP_J: addr = j_q;
      ST_WR_I: begin
        wren   = 1'b1;
        wrdata = sj_q;
      end
      ST_WR_J: begin
        addr   = j_q;
        wren   = 1'b1;
        wrdata = si_q;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ksa.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ksa
//  Purpose  : Self-checking bench for ksa (KEY_BYTES=3 and KEY_BYTES=1), with
//             a synchronous S memory model and a software ARC4 KSA reference.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ksa;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // KEY_BYTES = 3 instance
  logic        en3, rdy3, wren3;
  logic [23:0] key3;
  logic [7:0]  addr3, rddata3, wrdata3;
  // KEY_BYTES = 1 instance
  logic        en1, rdy1, wren1;
  logic [7:0]  key1;
  logic [7:0]  addr1, rddata1, wrdata1;

  ksa #(.KEY_BYTES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .rdy(rdy3), .key(key3),
    .addr(addr3), .rddata(rddata3), .wrdata(wrdata3), .wren(wren3)
  );

  ksa #(.KEY_BYTES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .rdy(rdy1), .key(key1),
    .addr(addr1), .rddata(rddata1), .wrdata(wrdata1), .wren(wren1)
  );

  // S memories, write log and activity counters
  logic [7:0] mem3 [256];
  logic [7:0] mem1 [256];
  logic [7:0] wla  [1024];
  logic [7:0] wld  [1024];
  logic       init3 = 1'b0, init1 = 1'b0;
  int         wr3_total = 0, busy3_total = 0, bad3 = 0;
  int         wr1_total = 0, busy1_total = 0, bad1 = 0;

  always @(posedge clk) begin
    if (init3) begin
      for (int k = 0; k < 256; k++) mem3[k] <= 8'(k);
    end else if (wren3) begin
      mem3[addr3] <= wrdata3;
    end
    rddata3 <= mem3[addr3];
    if (wren3) begin
      wla[wr3_total % 1024] <= addr3;
      wld[wr3_total % 1024] <= wrdata3;
      wr3_total <= wr3_total + 1;
    end
    if (!rdy3) busy3_total <= busy3_total + 1;
    if (wren3 && rdy3) bad3 <= bad3 + 1;
  end

  always @(posedge clk) begin
    if (init1) begin
      for (int k = 0; k < 256; k++) mem1[k] <= 8'(k);
    end else if (wren1) begin
      mem1[addr1] <= wrdata1;
    end
    rddata1 <= mem1[addr1];
    if (wren1) wr1_total <= wr1_total + 1;
    if (!rdy1) busy1_total <= busy1_total + 1;
    if (wren1 && rdy1) bad1 <= bad1 + 1;
  end

  // Checking
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Software ARC4 key schedule
  logic [7:0] ms [256];

  task automatic model_init();
    for (int k = 0; k < 256; k++) ms[k] = 8'(k);
  endtask

  task automatic model_run(input logic [23:0] k, input int nk);
    logic [7:0] j;
    logic [7:0] kb;
    logic [7:0] t;
    j = 8'h00;
    for (int i = 0; i < 256; i++) begin
      kb    = k[8*(nk-1-(i % nk)) +: 8];
      j     = j + ms[i] + kb;
      t     = ms[i];
      ms[i] = ms[j];
      ms[j] = t;
    end
  endtask

  task automatic compare_s(input string name, input bit use3);
    int bad;
    int first;
    bad   = 0;
    first = -1;
    for (int n = 0; n < 256; n++) begin
      if ((use3 ? mem3[n] : mem1[n]) !== ms[n]) begin
        bad++;
        if (first < 0) first = n;
      end
    end
    if (bad != 0) $display("first differing S index %0d", first);
    check(name, bad, 0);
  endtask

  task automatic wait_rdy3(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!rdy3) begin
      check({name, " rdy timeout"}, 32'd0, 32'd1);
    end
  endtask

  task automatic pulse_init3();
    @(negedge clk) init3 = 1'b1;
    @(negedge clk) init3 = 1'b0;
  endtask

  int last_wbase;

  task automatic run3(input string name, input logic [23:0] k, input logic [23:0] alt,
                      input bit change, input int exp_busy, input int exp_wr);
    int b0, w0, x0;
    pulse_init3();
    model_init();
    model_run(k, 3);
    b0 = busy3_total;
    w0 = wr3_total;
    x0 = bad3;
    last_wbase = w0;
    @(negedge clk);
    key3 = k;
    en3  = 1'b1;
    @(posedge clk);
    #1;
    en3 = 1'b0;
    check({name, " accept"}, rdy3, 0);
    if (change) begin
      repeat (100) @(negedge clk);
      key3 = alt;
    end
    wait_rdy3(name);
    check({name, " busy cycles"}, busy3_total - b0, exp_busy);
    check({name, " write cycles"}, wr3_total - w0, exp_wr);
    check({name, " writes while rdy"}, bad3 - x0, 0);
    compare_s({name, " final S"}, 1'b1);
  endtask

  typedef struct {
    logic [23:0] key;
    logic [23:0] alt;
    bit          change;
    int          exp_busy;
    int          exp_wr;
  } vec_t;

  vec_t vecs [4];

  // Zero-key first eight writes on identity S, as {addr, data}
  logic [15:0] zero_writes [8];

  initial begin
    int b0, w0;
    vecs[0] = '{key: 24'h00033C, alt: 24'h00033C, change: 1'b0, exp_busy: 1536, exp_wr: 512};
    vecs[1] = '{key: 24'h00033C, alt: 24'hA5A5A5, change: 1'b1, exp_busy: 1536, exp_wr: 512};
    vecs[2] = '{key: 24'h123456, alt: 24'h123456, change: 1'b0, exp_busy: 1536, exp_wr: 512};
    vecs[3] = '{key: 24'hFFFFFF, alt: 24'h000000, change: 1'b1, exp_busy: 1536, exp_wr: 512};
    zero_writes[0] = {8'd0, 8'd0};
    zero_writes[1] = {8'd0, 8'd0};
    zero_writes[2] = {8'd1, 8'd1};
    zero_writes[3] = {8'd1, 8'd1};
    zero_writes[4] = {8'd2, 8'd3};
    zero_writes[5] = {8'd3, 8'd2};
    zero_writes[6] = {8'd3, 8'd5};
    zero_writes[7] = {8'd5, 8'd2};

    rst_n = 1'b1;
    en3 = 1'b0; en1 = 1'b0;
    key3 = 24'h0; key1 = 8'h0;

    // Asynchronous reset between edges
    #3 rst_n = 1'b0;
    #1;
    check("reset rdy3", rdy3, 1);
    check("reset wren3", wren3, 0);
    check("reset addr3", addr3, 0);
    check("reset wrdata3", wrdata3, 0);
    check("reset rdy1", rdy1, 1);
    check("reset wren1", wren1, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle with en low: no writes
    w0 = wr3_total;
    repeat (10) @(posedge clk);
    #1;
    check("idle writes", wr3_total - w0, 0);
    check("idle rdy", rdy3, 1);

    // Zero key: first writes by hand, then the whole array
    run3("zero key", 24'h000000, 24'h000000, 1'b0, 1536, 512);
    for (int n = 0; n < 8; n++) begin
      check($sformatf("zero key write %0d addr", n), wla[(last_wbase + n) % 1024], zero_writes[n][15:8]);
      check($sformatf("zero key write %0d data", n), wld[(last_wbase + n) % 1024], zero_writes[n][7:0]);
    end

    // Table-driven runs
    for (int v = 0; v < 4; v++) begin
      run3($sformatf("vec%0d", v), vecs[v].key, vecs[v].alt, vecs[v].change,
           vecs[v].exp_busy, vecs[v].exp_wr);
    end

    // en held high: the second run starts on the first rdy cycle
    pulse_init3();
    model_init();
    model_run(24'h00033C, 3);
    model_run(24'h00033C, 3);
    b0 = busy3_total;
    @(negedge clk);
    key3 = 24'h00033C;
    en3  = 1'b1;
    @(posedge clk);
    #1;
    check("hold-en accept", rdy3, 0);
    wait_rdy3("hold-en first");
    @(posedge clk);
    #1;
    check("hold-en restart no gap", rdy3, 0);
    en3 = 1'b0;
    wait_rdy3("hold-en second");
    check("hold-en busy cycles", busy3_total - b0, 3072);
    compare_s("hold-en final S", 1'b1);

    // Reset in the middle of a run
    pulse_init3();
    @(negedge clk);
    key3 = 24'h00033C;
    en3  = 1'b1;
    @(posedge clk);
    #1;
    en3 = 1'b0;
    repeat (700) @(posedge clk);
    #2;
    check("mid-run wren before reset", wren3, 1);
    rst_n = 1'b0;
    #1;
    check("mid-run reset wren", wren3, 0);
    check("mid-run reset rdy", rdy3, 1);
    check("mid-run reset addr", addr3, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run3("after reset", 24'h00033C, 24'h00033C, 1'b0, 1536, 512);

    // One-byte key instance
    @(negedge clk) init1 = 1'b1;
    @(negedge clk) init1 = 1'b0;
    model_init();
    model_run(24'h0000FF, 1);
    b0 = busy1_total;
    w0 = wr1_total;
    @(negedge clk);
    key1 = 8'hFF;
    en1  = 1'b1;
    @(posedge clk);
    #1;
    en1 = 1'b0;
    check("kb1 accept", rdy1, 0);
    for (int n = 0; n < 2000 && !rdy1; n++) @(negedge clk);
    check("kb1 done", rdy1, 1);
    check("kb1 busy cycles", busy1_total - b0, 1536);
    check("kb1 write cycles", wr1_total - w0, 512);
    check("kb1 writes while rdy", bad1, 0);
    compare_s("kb1 final S", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
